ser_tx_piso: RTL and testbench



---
 rtl/ser_pkg.sv | 18 +
 rtl/bit_timer.sv | 40 ++++
 rtl/ser_tx_piso.sv | 130 +++++++++++++
 tb/tb_ser_tx_piso.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ser_pkg.sv
// Shared definitions for the serial link: FSM state encoding and default
// frame geometry, so transmitter and a future receiver agree.
package ser_pkg;

   localparam int DEF_DATA_W       = 8;
   localparam int DEF_CLKS_PER_BIT = 4;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and pulses Tick
// in the last cycle of each bit period. Clears whenever En is low.
module bit_timer
   import ser_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
   input  logic Clk,
   input  logic Rst,
   input  logic En,
   output logic Tick
);

   localparam int               CNT_W = cnt_width(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count and wrap pulse; with CLKS_PER_BIT=1 Tick simply follows En.
   always_comb begin
      Tick  = En && (cnt_q == LAST);
      cnt_d = cnt_q;
      if (!En || Tick) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Counter register.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/ser_tx_piso.sv
// Serial transmitter: accepts a word on Valid&&Ready and shifts it out as
// start bit (0), DATA_W data bits LSB-first, stop bit (1). Tx idles high.
//
// Handshake: Ready is high only in IDLE with Rst low and never looks at
// Valid; a word is taken at the rising edge where Valid and Ready are both
// high. Din/Valid are ignored from then until the frame returns to IDLE.
module ser_tx_piso
   import ser_pkg::*;
#(
   parameter int DATA_W       = DEF_DATA_W,
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic [DATA_W-1:0] Din,
   input  logic              Valid,
   output logic              Ready,
   output logic              Tx,
   output logic              Busy,
   output logic              Done,
   output logic [1:0]        dbg_state
);

   if (DATA_W < 1) begin : g_bad_data_w
      $error("ser_tx_piso: DATA_W must be >= 1");
   end
   if (CLKS_PER_BIT < 1) begin : g_bad_clks_per_bit
      $error("ser_tx_piso: CLKS_PER_BIT must be >= 1");
   end

   localparam int                BIT_W    = cnt_width(DATA_W);
   localparam logic [BIT_W-1:0]  LAST_IDX = BIT_W'(DATA_W - 1);

   logic [1:0]        state_q,   state_d;
   logic              busy_q,    busy_d;
   logic              tx_q,      tx_d;
   logic              done_q,    done_d;
   logic [BIT_W-1:0]  bit_idx_q, bit_idx_d;
   logic [DATA_W-1:0] shift_q,   shift_d;
   logic [DATA_W-1:0] shift_nxt;
   logic              tick;

   bit_timer #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_bit_timer (
      .Clk  (Clk),
      .Rst  (Rst),
      .En   (busy_q),
      .Tick (tick)
   );

   assign Ready     = (state_q == ST_IDLE) && !Rst;
   assign Tx        = tx_q;
   assign Busy      = busy_q;
   assign Done      = done_q;
   assign dbg_state = state_q;

   // Frame sequencing: each non-IDLE state lasts one bit period, Tx is
   // registered so it changes on the same edge as the state.
   always_comb begin
      state_d   = state_q;
      tx_d      = tx_q;
      done_d    = 1'b0;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      shift_nxt = shift_q >> 1;
      case (state_q)
         ST_IDLE: begin
            tx_d = 1'b1;
            if (Valid && Ready) begin
               state_d   = ST_START;
               shift_d   = Din;
               bit_idx_d = '0;
               tx_d      = 1'b0;
            end
         end
         ST_START: begin
            if (tick) begin
               state_d   = ST_DATA;
               bit_idx_d = '0;
               tx_d      = shift_q[0];
            end
         end
         ST_DATA: begin
            if (tick) begin
               shift_d = shift_nxt;
               if (bit_idx_q == LAST_IDX) begin
                  state_d = ST_STOP;
                  tx_d    = 1'b1;
               end else begin
                  bit_idx_d = bit_idx_q + BIT_W'(1);
                  tx_d      = shift_nxt[0];
               end
            end
         end
         ST_STOP: begin
            if (tick) begin
               state_d = ST_IDLE;
               tx_d    = 1'b1;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State and datapath registers; reset discards any partial frame.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q   <= ST_IDLE;
         busy_q    <= 1'b0;
         tx_q      <= 1'b1;
         done_q    <= 1'b0;
         bit_idx_q <= '0;
         shift_q   <= '0;
      end else begin
         state_q   <= state_d;
         busy_q    <= busy_d;
         tx_q      <= tx_d;
         done_q    <= done_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
      end
   end

endmodule

// File: tb/tb_ser_tx_piso.sv
// Bench for ser_tx_piso: an 8-bit/4-clock instance and a 4-bit/1-clock
// instance share clock and reset. Expected {tx,busy,done} per cycle is
// queued when a word is offered and popped as the line is observed.
module tb_ser_tx_piso;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic [7:0] din;
   logic       valid;
   logic       ready, tx, busy, done;
   logic [1:0] dbg_state;

   logic [3:0] din_b;
   logic       valid_b;
   logic       ready_b, tx_b, busy_b, done_b;
   logic [1:0] dbg_state_b;

   ser_tx_piso #(.DATA_W(8), .CLKS_PER_BIT(4)) u_dut (
      .Clk(clk), .Rst(rst), .Din(din), .Valid(valid), .Ready(ready),
      .Tx(tx), .Busy(busy), .Done(done), .dbg_state(dbg_state)
   );

   ser_tx_piso #(.DATA_W(4), .CLKS_PER_BIT(1)) u_dut_b (
      .Clk(clk), .Rst(rst), .Din(din_b), .Valid(valid_b), .Ready(ready_b),
      .Tx(tx_b), .Busy(busy_b), .Done(done_b), .dbg_state(dbg_state_b)
   );

   // ---------------- scoreboard ----------------
   logic [2:0] exp_q[$];   // {tx, busy, done} per cycle
   logic [2:0] exp_v;
   logic [2:0] obs_v;
   int         n_checks = 0;
   int         n_pass   = 0;

   // Queue the per-cycle line image of one frame: start, data LSB-first, stop.
   task automatic push_frame(input logic [7:0] data, input int dw, input int cpb);
      logic b;
      for (int s = 0; s < dw + 2; s++) begin
         if (s == 0)           b = 1'b0;
         else if (s == dw + 1) b = 1'b1;
         else                  b = data[s-1];
         for (int k = 0; k < cpb; k++) exp_q.push_back({b, 1'b1, 1'b0});
      end
   endtask

   // ---------------- driver / test tasks ----------------
   task automatic test_reset();
      rst = 1'b1; valid = 1'b1; din = 8'hA5; valid_b = 1'b1; din_b = 4'hF;
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++;
         if ({tx, busy, done, ready} !== 4'b1000)
            $display("FAIL reset_a cyc=%0d {tx,busy,done,ready} got %b want 1000", i, {tx, busy, done, ready});
         else n_pass++;
         n_checks++;
         if ({tx_b, busy_b, done_b, ready_b} !== 4'b1000)
            $display("FAIL reset_b cyc=%0d {tx,busy,done,ready} got %b want 1000", i, {tx_b, busy_b, done_b, ready_b});
         else n_pass++;
         @(posedge clk); #1;
      end
      rst = 1'b0; valid = 1'b0; valid_b = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({ready, ready_b, done, dbg_state} !== 5'b11000)
         $display("FAIL reset_release {ready,ready_b,done,state} got %b want 11000", {ready, ready_b, done, dbg_state});
      else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_single_frame();
      int n;
      din = 8'hA5; valid = 1'b1;
      @(posedge clk); #1;                 // E0
      valid = 1'b0;
      push_frame(8'hA5, 8, 4);
      exp_q.push_back(3'b101);
      n = exp_q.size();
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         obs_v = {tx, busy, done}; exp_v = exp_q.pop_front();
         n_checks++;
         if (obs_v !== exp_v)
            $display("FAIL single c=%0d {tx,busy,done} got %b want %b", c, obs_v, exp_v);
         else n_pass++;
         n_checks++;
         if (ready !== (c == n - 1))
            $display("FAIL single_ready c=%0d got %b want %b", c, ready, (c == n - 1));
         else n_pass++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_back_to_back();
      int n;
      din = 8'h00; valid = 1'b1;
      @(posedge clk); #1;                 // E0
      din = 8'hFF;                        // taken at the first frame's end
      push_frame(8'h00, 8, 4);
      exp_q.push_back(3'b101);
      push_frame(8'hFF, 8, 4);
      exp_q.push_back(3'b101);
      n = exp_q.size();
      for (int c = 0; c < n; c++) begin
         if (c == 41) valid = 1'b0;
         @(negedge clk);
         obs_v = {tx, busy, done}; exp_v = exp_q.pop_front();
         n_checks++;
         if (obs_v !== exp_v)
            $display("FAIL b2b c=%0d {tx,busy,done} got %b want %b", c, obs_v, exp_v);
         else n_pass++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_mid_reset();
      int n;
      din = 8'h5A; valid = 1'b1;
      @(posedge clk); #1;                 // E0
      valid = 1'b0;
      push_frame(8'h5A, 8, 4);
      for (int c = 0; c < 21; c++) begin
         if (c == 14) rst = 1'b1;
         if (c == 15) begin
            rst = 1'b0;
            exp_q.delete();
            repeat (6) exp_q.push_back(3'b100);
         end
         @(negedge clk);
         obs_v = {tx, busy, done}; exp_v = exp_q.pop_front();
         n_checks++;
         if (obs_v !== exp_v)
            $display("FAIL mid_reset c=%0d {tx,busy,done} got %b want %b", c, obs_v, exp_v);
         else n_pass++;
         if (c == 15) begin
            n_checks++;
            if (ready !== 1'b1) $display("FAIL mid_reset_ready got %b want 1", ready);
            else n_pass++;
         end
         @(posedge clk); #1;
      end
      // A fresh word goes out intact after the aborted frame.
      din = 8'h3C; valid = 1'b1;
      @(posedge clk); #1;
      valid = 1'b0;
      push_frame(8'h3C, 8, 4);
      exp_q.push_back(3'b101);
      n = exp_q.size();
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         obs_v = {tx, busy, done}; exp_v = exp_q.pop_front();
         n_checks++;
         if (obs_v !== exp_v)
            $display("FAIL after_reset c=%0d {tx,busy,done} got %b want %b", c, obs_v, exp_v);
         else n_pass++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_ignored_input();
      int n;
      din = 8'h81; valid = 1'b1;
      @(posedge clk); #1;                 // E0
      push_frame(8'h81, 8, 4);
      exp_q.push_back(3'b101);
      repeat (5) exp_q.push_back(3'b100);
      n = exp_q.size();
      for (int c = 0; c < n; c++) begin
         if (c < 40) begin
            valid = 1'($urandom_range(0, 1));
            din   = 8'($urandom_range(0, 255));
         end else begin
            valid = 1'b0;
         end
         @(negedge clk);
         obs_v = {tx, busy, done}; exp_v = exp_q.pop_front();
         n_checks++;
         if (obs_v !== exp_v)
            $display("FAIL ignored c=%0d {tx,busy,done} got %b want %b", c, obs_v, exp_v);
         else n_pass++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_one_clk_per_bit();
      int n;
      din_b = 4'b1010; valid_b = 1'b1;
      @(posedge clk); #1;                 // E0
      valid_b = 1'b0;
      push_frame(8'h0A, 4, 1);
      exp_q.push_back(3'b101);
      exp_q.push_back(3'b100);
      n = exp_q.size();
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         obs_v = {tx_b, busy_b, done_b}; exp_v = exp_q.pop_front();
         n_checks++;
         if (obs_v !== exp_v)
            $display("FAIL cpb1 c=%0d {tx,busy,done} got %b want %b", c, obs_v, exp_v);
         else n_pass++;
         @(posedge clk); #1;
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      rst = 1'b1; din = '0; valid = 1'b0; din_b = '0; valid_b = 1'b0;
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_mid_reset();
      test_ignored_input();
      test_one_clk_per_bit();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
